mips_run_ctrl: RTL
==================

# mips_run_ctrl

Run/debug controller for the single-cycle MIPS core. It sits between the host (testbench or debug port) and the core. It owns the core's reset and clock-enable, and sequences execution in run, single/multi-step and halt modes. It stops the core on a PC breakpoint or a `break` instruction and keeps cycle and retired-instruction counters. Each core cycle with `cpu_en`=1 retires exactly the instruction at `pc_addr`.

## Interface
- `CNT_WIDTH`, 32, width of `cycle_cnt` / `instr_cnt`
- `RST_HOLD_CYC`, 2, cycles `cpu_rst` stays high after `rst` deasserts (≥1)
- `clk`  in  1  system clock, rising edge
- `rst`  in  1  reset, synchronous, active-high
- `cmd_valid`  in  1  host command strobe
- `cmd_op`  in  2  00 RUN, 01 STEP, 10 HALT, 11 CLR
- `step_count`  in  16  instructions per STEP; 0 treated as 1
- `cmd_ready`  out  1  command accepted on `cmd_valid & cmd_ready`
- `bp_en`  in  1  breakpoint enable
- `bp_addr`  in  32  breakpoint PC
- `pc_addr`  in  32  core current PC
- `instr`  in  32  core current instruction
- `cpu_rst`  out  1  reset to core, active-high
- `cpu_en`  out  1  core enable; gates PC, register-file and data-memory writes
- `state`  out  2  00 RST_HOLD, 01 HALTED, 10 RUN, 11 STEP
- `halted`  out  1  state==HALTED
- `halt_cause`  out  2  0 host/reset, 1 breakpoint, 2 step done, 3 `break` instr
- `cycle_cnt`  out  CNT_WIDTH  cycles spent in RUN/STEP
- `instr_cnt`  out  CNT_WIDTH  cycles with `cpu_en`=1

## Operation
- `brk` = (`instr[31:26]`==0 && `instr[5:0]`==6'h0D). `bp_hit` = `bp_en` && `pc_addr`==`bp_addr` && !`first`.
- `first` is a flag set on every entry to RUN/STEP and cleared after one cycle, so resuming at a breakpointed PC does not re-trigger.
- `cpu_en` = (RUN|STEP) && !`bp_hit` && !`brk`. It is combinational from state, `pc_addr` and `instr`; there is no path from `cmd_*`.
- `brk` is checked even when `first`=1. A `break` therefore halts again on every resume; the host must CLR or let the core be patched.
- `cmd_ready` = (state != RST_HOLD).
- RST_HOLD:
  - `cpu_rst`=1.
  - Hold counter loads `RST_HOLD_CYC` while `rst`=1, then counts down. At 0 the next state is HALTED with cause 0.
- HALTED:
  - RUN → RUN.
  - STEP → STEP, with `remain` = max(`step_count`,1).
  - HALT → no effect.
  - CLR → RST_HOLD; counters cleared; hold counter reloaded.
- RUN:
  - `bp_hit` → HALTED cause 1. `brk` → HALTED cause 3; breakpoint has priority when both are true.
  - Accepted HALT → HALTED cause 0 at the next edge. The current cycle still executes if `cpu_en`=1.
  - CLR → RST_HOLD.
  - RUN and STEP commands are accepted and ignored.
- STEP:
  - Same stop rules as RUN.
  - Each `cpu_en` cycle decrements `remain`. If `remain`==1 at that edge, go to HALTED cause 2.
  - If a stop condition and an accepted HALT coincide, the stop condition's cause wins.
- Priority at one edge: `rst` > CLR > bp/brk > step done > HALT.
- Counters:
  - `cycle_cnt` increments each cycle in RUN/STEP.
  - `instr_cnt` increments each cycle `cpu_en`=1.
  - Both saturate at all-ones and clear on `rst` or CLR.

## Timing
- Reset values:
  - `state`=RST_HOLD, `cpu_rst`=1, `cpu_en`=0, `cmd_ready`=0.
  - `halted`=0, `halt_cause`=0, counters 0, `remain`=0, `first`=0.
- `rst` falls before edge k. `cpu_rst` stays 1 through edge k+`RST_HOLD_CYC`-1. State is HALTED after edge k+`RST_HOLD_CYC`.
- RUN accepted at edge e: state RUN after e, and `cpu_en` can be 1 in the cycle following e.
- Stop latency: the stopping cycle has `cpu_en`=0, so the PC is frozen at the stop address. `halted`=1 after the same edge.
- STEP N with no stops: exactly N cycles with `cpu_en`=1, then HALTED. `instr_cnt` rises by N.
- Command issued during RST_HOLD: not accepted; the host keeps `cmd_valid` high.

## Test plan
- Reset: hold `rst` 3 cycles, then release. Require `cpu_rst`=1 for 2 more cycles, then `state`=01, `halted`=1, `cause`=0, counters 0.
- Breakpoint: core starts at 0x3000 with straight-line code, `bp_addr`=0x3044, RUN. Require HALTED cause 1 with `pc_addr`=0x3044 and `instr_cnt`=17. A second RUN retires 0x3044 (no re-hit); `instr_cnt`=18 after one cycle.
- STEP: `step_count`=3 from 0x3000. Require 3 `cpu_en` pulses, PC=0x300C, cause 2. `step_count`=0 gives 1 instruction.
- Host HALT: HALT during RUN at edge e. Require `cpu_en`=0 from the cycle after e and cause 0. `cycle_cnt` equals the number of RUN cycles.
- `break` at 0x3010 during STEP 10: require halt at 0x3010, cause 3, `instr_cnt`=4. BREAK and bp at the same PC → cause 1.
- CLR mid-RUN: require RST_HOLD for 2 cycles with `cpu_rst`=1, counters 0, then HALTED. With `CNT_WIDTH`=4, run 20 cycles and require `cycle_cnt`=15 (saturated).

Source files
------------

// File: rtl/mips_run_ctrl_if.sv
// rtl/mips_run_ctrl_if.sv - host command handshake between debug host and run controller
interface mips_run_ctrl_if;
  logic        cmd_valid;
  logic [1:0]  cmd_op;
  logic [15:0] step_count;
  logic        cmd_ready;

  modport master (output cmd_valid, output cmd_op, output step_count, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_op, input step_count, output cmd_ready);
endinterface

// File: rtl/mips_run_ctrl.sv
// rtl/mips_run_ctrl.sv - run/step/halt sequencer for the single-cycle MIPS core
module mips_run_ctrl #(
  parameter int CNT_WIDTH    = 32,
  parameter int RST_HOLD_CYC = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  mips_run_ctrl_if.slave       cmd,
  input  logic                 bp_en,
  input  logic [31:0]          bp_addr,
  input  logic [31:0]          pc_addr,
  input  logic [31:0]          instr,
  output logic                 cpu_rst,
  output logic                 cpu_en,
  output logic [1:0]           state,
  output logic                 halted,
  output logic [1:0]           halt_cause,
  output logic [CNT_WIDTH-1:0] cycle_cnt,
  output logic [CNT_WIDTH-1:0] instr_cnt
);
  localparam int HW = (RST_HOLD_CYC < 1) ? 1 : $clog2(RST_HOLD_CYC + 1);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(RST_HOLD_CYC);

  localparam logic [1:0] OP_RUN  = 2'b00;
  localparam logic [1:0] OP_STEP = 2'b01;
  localparam logic [1:0] OP_HALT = 2'b10;
  localparam logic [1:0] OP_CLR  = 2'b11;

  typedef enum logic [1:0] {
    ST_RST_HOLD = 2'b00,
    ST_HALTED   = 2'b01,
    ST_RUN      = 2'b10,
    ST_STEP     = 2'b11
  } state_t;

  state_t      st;
  logic [HW-1:0] hold_cnt;
  logic [15:0] remain;
  logic        first;
  logic        brk;
  logic        bp_hit;
  logic        active;
  logic        acc;

  assign brk    = (instr[31:26] == 6'd0) && (instr[5:0] == 6'h0D);
  // first suppresses the breakpoint on the resume cycle so the stopped PC can retire
  assign bp_hit = bp_en && (pc_addr == bp_addr) && !first;
  assign active = (st == ST_RUN) || (st == ST_STEP);
  assign cpu_en = active && !bp_hit && !brk;
  assign acc    = cmd.cmd_valid && cmd.cmd_ready;

  assign cmd.cmd_ready = (st != ST_RST_HOLD);
  assign cpu_rst       = (st == ST_RST_HOLD);
  assign halted        = (st == ST_HALTED);
  assign state         = st;

  always_ff @(posedge clk) begin
    if (rst) begin
      st         <= ST_RST_HOLD;
      hold_cnt   <= HOLD_LOAD;
      halt_cause <= 2'd0;
      cycle_cnt  <= '0;
      instr_cnt  <= '0;
      remain     <= 16'd0;
      first      <= 1'b0;
    end else begin
      first <= 1'b0;
      if (active && (cycle_cnt != '1)) cycle_cnt <= cycle_cnt + 1'b1;
      if (cpu_en && (instr_cnt != '1)) instr_cnt <= instr_cnt + 1'b1;

      case (st)
        ST_RST_HOLD: begin
          if (hold_cnt == '0) begin
            st         <= ST_HALTED;
            halt_cause <= 2'd0;
          end else begin
            hold_cnt <= hold_cnt - 1'b1;
          end
        end
        ST_HALTED: begin
          if (acc) begin
            case (cmd.cmd_op)
              OP_RUN: begin
                st    <= ST_RUN;
                first <= 1'b1;
              end
              OP_STEP: begin
                st     <= ST_STEP;
                remain <= (cmd.step_count == 16'd0) ? 16'd1 : cmd.step_count;
                first  <= 1'b1;
              end
              OP_CLR: begin
                st        <= ST_RST_HOLD;
                hold_cnt  <= HOLD_LOAD;
                cycle_cnt <= '0;
                instr_cnt <= '0;
              end
              default: ;
            endcase
          end
        end
        default: begin
          // RUN and STEP share stop rules; later assignments here override the counter bumps
          if (acc && cmd.cmd_op == OP_CLR) begin
            st        <= ST_RST_HOLD;
            hold_cnt  <= HOLD_LOAD;
            cycle_cnt <= '0;
            instr_cnt <= '0;
          end else if (bp_hit) begin
            st         <= ST_HALTED;
            halt_cause <= 2'd1;
          end else if (brk) begin
            st         <= ST_HALTED;
            halt_cause <= 2'd3;
          end else begin
            if (st == ST_STEP && cpu_en) remain <= remain - 1'b1;
            if (st == ST_STEP && cpu_en && remain == 16'd1) begin
              st         <= ST_HALTED;
              halt_cause <= 2'd2;
            end else if (acc && cmd.cmd_op == OP_HALT) begin
              st         <= ST_HALTED;
              halt_cause <= 2'd0;
            end
          end
        end
      endcase
    end
  end
endmodule
